// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + result register around the combinational 4-bit ALU.
// Commands are issued from the FIFO head; results leave on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [1:0]               in_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_opcode,
  input  logic [4:0]               alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_result,
  output logic [1:0]               out_op,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic             push;
  logic             load;

  // Full blocks input even when a pop happens in the same cycle.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    if (count != '0) begin
      alu_a      = head.a;
      alu_b      = head.b;
      alu_opcode = head.op;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op, tag: tag_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output slot: refill whenever free or being drained, else clear on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
      out_tag    <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_op     <= head.op;
      out_tag    <= head.tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: queue-based reference model plus directed
// scenarios and randomized traffic with occasional resets.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic [1:0]       in_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_opcode;
  logic [4:0]       alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_result;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    count;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_tag(out_tag),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_alu(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    case (op)
      2'd0:    return 5'(a) + 5'(b);
      2'd1:    return 5'(a) - 5'(b);
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Behavioural ALU sitting on the sequencer's issue port.
  always_comb alu_result = ref_alu(alu_a, alu_b, alu_opcode);

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // Reference model: pending commands and the output slot.
  cmd_t             mq[$];
  bit               armed = 0;
  bit               sv;
  logic [4:0]       sr;
  logic [1:0]       so;
  logic [TAG_W-1:0] st;
  logic [TAG_W-1:0] tagc;
  logic [TAG_W-1:0] last_tag;
  logic [TAG_W-1:0] prev_tag;
  int               ndeliv;
  bit               ld;
  bit               pu;

  always @(negedge clk) begin
    if (armed) begin
      check("count",      32'(count),      32'(mq.size()));
      check("in_ready",   32'(in_ready),   32'(mq.size() < int'(DEPTH)));
      check("out_valid",  32'(out_valid),  32'(sv));
      check("out_result", 32'(out_result), 32'(sr));
      check("out_op",     32'(out_op),     32'(so));
      check("out_tag",    32'(out_tag),    32'(st));
      check("alu_a",      32'(alu_a),      mq.size() > 0 ? 32'(mq[0].a)  : 32'd0);
      check("alu_b",      32'(alu_b),      mq.size() > 0 ? 32'(mq[0].b)  : 32'd0);
      check("alu_op",     32'(alu_opcode), mq.size() > 0 ? 32'(mq[0].op) : 32'd0);
    end
    if (!rst_n) begin
      mq.delete();
      sv = 0; sr = '0; so = '0; st = '0; tagc = '0;
      last_tag = '0; prev_tag = '0; ndeliv = 0;
      armed = 1;
    end else if (armed) begin
      pu = in_valid && (mq.size() < int'(DEPTH));
      ld = (mq.size() > 0) && (!sv || out_ready);
      if (sv && out_ready) begin
        prev_tag = last_tag;
        last_tag = st;
        ndeliv++;
      end
      if (ld) begin
        sv = 1;
        sr = ref_alu(mq[0].a, mq[0].b, mq[0].op);
        so = mq[0].op;
        st = mq[0].tag;
        void'(mq.pop_front());
      end else if (sv && out_ready) begin
        sv = 0;
      end
      if (pu) begin
        mq.push_back('{a: in_a, b: in_b, op: in_op, tag: tagc});
        tagc = tagc + TAG_W'(1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    rst_n    = 1'b1;
  endtask

  task automatic push(logic [3:0] a, logic [3:0] b, logic [1:0] op);
    bit ok;
    bit acc;
    ok       = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    for (int i = 0; i < 64; i++) begin
      acc = in_ready;
      cyc();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'(ok), 32'd1);
  endtask

  logic [3:0] va[4] = '{4'd15, 4'd3, 4'd12, 4'd5};
  logic [3:0] vb[4] = '{4'd15, 4'd5, 4'd10, 4'd2};
  logic [1:0] vo[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [4:0] vr[4] = '{5'h1E, 5'h1E, 5'h08, 5'h07};
  logic [3:0] fa, fb;
  logic [1:0] fo;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_count",     32'(count),     32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);

    // Single command latency
    push(4'd9, 4'd8, 2'd0);
    check("single_e0_valid", 32'(out_valid), 32'd0);
    cyc();
    check("single_e1_valid",  32'(out_valid),  32'd1);
    check("single_e1_result", 32'(out_result), 32'h11);
    check("single_e1_op",     32'(out_op),     32'd0);
    check("single_e1_tag",    32'(out_tag),    32'd0);
    cyc();
    check("single_e2_valid", 32'(out_valid), 32'd0);

    // Back-to-back, one result per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(va[i], vb[i], vo[i]);
      if (i > 0) begin
        check("b2b_result", 32'(out_result), 32'(vr[i-1]));
        check("b2b_tag",    32'(out_tag),    32'(i - 1));
      end
    end
    cyc();
    check("b2b_last_result", 32'(out_result), 32'(vr[3]));
    check("b2b_last_tag",    32'(out_tag),    32'd3);
    cyc();

    // Backpressure: fill slot + FIFO, sixth push must stall
    do_reset();
    out_ready = 1'b0;
    fa = 4'($urandom); fb = 4'($urandom); fo = 2'($urandom);
    push(fa, fb, fo);
    for (int i = 0; i < 4; i++) push(4'($urandom), 4'($urandom), 2'($urandom));
    check("bp_count",  32'(count),     32'd4);
    check("bp_ready",  32'(in_ready),  32'd0);
    check("bp_valid",  32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_a = 4'($urandom); in_b = 4'($urandom); in_op = 2'($urandom);
    repeat (3) cyc();
    check("bp_hold_ready",  32'(in_ready),   32'd0);
    check("bp_hold_result", 32'(out_result), 32'(ref_alu(fa, fb, fo)));
    check("bp_hold_tag",    32'(out_tag),    32'd0);
    out_ready = 1'b1;
    push(in_a, in_b, in_op);
    repeat (8) cyc();
    check("bp_delivered", 32'(ndeliv), 32'd6);

    // Tag wrap across 257 commands
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) push(4'($urandom), 4'($urandom), 2'($urandom));
    repeat (4) cyc();
    check("wrap_delivered", 32'(ndeliv),   32'd257);
    check("wrap_prev_tag",  32'(prev_tag), 32'd255);
    check("wrap_last_tag",  32'(last_tag), 32'd0);

    // Reset in the middle of a stalled stream
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'($urandom), 4'($urandom), 2'($urandom));
    check("mid_count", 32'(count),     32'd3);
    check("mid_valid", 32'(out_valid), 32'd1);
    do_reset();
    check("mid_rst_count", 32'(count),     32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_tag",   32'(out_tag),   32'd0);
    out_ready = 1'b1;
    push(4'd1, 4'd2, 2'd1);
    cyc();
    check("mid_new_valid",  32'(out_valid),  32'd1);
    check("mid_new_tag",    32'(out_tag),    32'd0);
    check("mid_new_result", 32'(out_result), 32'h1F);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    check("final_count", 32'(count),     32'd0);
    check("final_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
